// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode/funct3 constants, mem_stage state enum and access helpers
package cpu_pkg;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] JUMP_DEFAULT = 32'h4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } mem_state_t;

  // Index of the final byte: (1 << sel[1:0]) - 1, truncated to the 2-bit counter.
  function automatic logic [1:0] last_index(input logic [2:0] sel);
    logic [1:0] idx;
    case (sel[1:0])
      2'b00:   idx = 2'd0;
      2'b01:   idx = 2'd1;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] sel, input logic [1:0] addr_lo);
    logic mis;
    case (sel)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - byte-serial memory-controller port between mem_stage and the controller
interface mem_stage_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic [7:0]  mem_rdata_i;
  logic        mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/mem_stage_load_ext.sv
// rtl/mem_stage_load_ext.sv - sign/zero extension of an assembled load word by funct3
module load_ext
  import cpu_pkg::*;
(
  input  logic [31:0] asm_word,
  input  logic [2:0]  sel,
  output logic [31:0] result
);

  always_comb begin
    case (sel)
      F3_B:    result = {{24{asm_word[7]}}, asm_word[7:0]};
      F3_H:    result = {{16{asm_word[15]}}, asm_word[15:0]};
      F3_BU:   result = {24'h0, asm_word[7:0]};
      F3_HU:   result = {16'h0, asm_word[15:0]};
      default: result = asm_word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I memory stage, byte-serial loads/stores; MEM_STAGE_MISALIGN_TRAP_EN enables misalign trap
module mem_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        e_i,
  input  logic [4:0]  op_i,
  input  logic [2:0]  sel_i,
  input  logic [4:0]  regd_i,
  input  logic [31:0] res_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] jump_i,
  output logic        stall_o,
  output logic        e_o,
  output logic        we_o,
  output logic [4:0]  regd_o,
  output logic [31:0] res_o,
  output logic [4:0]  op_o,
  output logic [31:0] jump_o,
  output logic        misalign_o,
  mem_stage_if.master bus
);

  mem_state_t  state, state_n;
  logic [1:0]  cnt, last;
  logic [4:0]  op_q, regd_q;
  logic [2:0]  sel_q;
  logic [31:0] data_q, jump_q, asm_q, asm_next, load_res;
  logic        accept, is_mem, trap, mem_start, beat, done;

  assign is_mem = (op_i == OP_LOAD) || (op_i == OP_STORE);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign trap = is_misaligned(sel_i, addr_i[1:0]);
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else if (rdy) state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (mem_start) state_n = ST_XFER;
      ST_XFER: if (done)      state_n = ST_IDLE;
      default:                state_n = ST_IDLE;
    endcase
  end

  // Acks only count in XFER, which is exactly when req is high.
  always_comb begin
    accept    = rdy && e_i && (state == ST_IDLE);
    mem_start = accept && is_mem && !trap;
    beat      = rdy && (state == ST_XFER) && bus.mem_ack_i;
    done      = beat && (cnt == last);
    stall_o   = (state == ST_XFER);
  end

  always_comb begin
    asm_next = asm_q;
    asm_next[{cnt, 3'b000} +: 8] = bus.mem_rdata_i;
  end

  load_ext u_load_ext (
    .asm_word (asm_next),
    .sel      (sel_q),
    .result   (load_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_o             <= 1'b0;
      we_o            <= 1'b0;
      regd_o          <= '0;
      res_o           <= '0;
      op_o            <= '0;
      jump_o          <= JUMP_DEFAULT;
      misalign_o      <= 1'b0;
      bus.mem_req_o   <= 1'b0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
      cnt             <= '0;
      last            <= '0;
      op_q            <= '0;
      sel_q           <= '0;
      regd_q          <= '0;
      data_q          <= '0;
      jump_q          <= JUMP_DEFAULT;
      asm_q           <= '0;
    end else if (rdy) begin
      e_o        <= 1'b0;
      we_o       <= 1'b0;
      misalign_o <= accept && is_mem && trap;
      if (accept) begin
        if (!is_mem) begin
          e_o    <= 1'b1;
          we_o   <= (regd_i != 5'd0) && (op_i != OP_BRANCH);
          regd_o <= regd_i;
          res_o  <= res_i;
          op_o   <= op_i;
          jump_o <= jump_i;
        end else if (trap) begin
          e_o    <= 1'b1;
          regd_o <= regd_i;
          res_o  <= '0;
          op_o   <= op_i;
          jump_o <= jump_i;
        end else begin
          op_q            <= op_i;
          sel_q           <= sel_i;
          regd_q          <= regd_i;
          data_q          <= res_i;
          jump_q          <= jump_i;
          asm_q           <= '0;
          cnt             <= 2'd0;
          last            <= last_index(sel_i);
          bus.mem_req_o   <= 1'b1;
          bus.mem_we_o    <= (op_i == OP_STORE);
          bus.mem_addr_o  <= addr_i;
          bus.mem_wdata_o <= res_i[7:0];
        end
      end else if (beat) begin
        asm_q <= asm_next;
        if (done) begin
          bus.mem_req_o <= 1'b0;
          e_o           <= 1'b1;
          regd_o        <= regd_q;
          op_o          <= op_q;
          jump_o        <= jump_q;
          if (op_q == OP_LOAD) begin
            res_o <= load_res;
            we_o  <= (regd_q != 5'd0);
          end else begin
            res_o <= '0;
          end
        end else begin
          cnt             <= cnt + 2'd1;
          bus.mem_addr_o  <= bus.mem_addr_o + 32'd1;
          bus.mem_wdata_o <= data_q[{cnt + 2'd1, 3'b000} +: 8];
        end
      end
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage for the RV32I core. It sits directly downstream of the execute stage and consumes its registered outputs: op, funct3 select, destination register, ALU result/store data, effective address and jump offset. Loads and stores run as byte-serial transactions over the 8-bit memory-controller port, and the upstream stage is stalled until the transfer completes. All other ops pass through in one cycle to writeback.

## Interface
Parameters: none.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- rdy  in  1  global ready; low freezes all state
- e_i  in  1  upstream result valid
- op_i  in  5  opcode[6:2]; load = 00000, store = 01000, branch = 11000
- sel_i  in  3  funct3
- regd_i  in  5  destination register
- res_i  in  32  ALU result; holds store data for stores
- addr_i  in  32  effective address (loads/stores)
- jump_i  in  32  next-PC offset, passed through
- stall_o  out  1  access in progress; upstream must hold
- e_o  out  1  writeback valid, one-cycle pulse
- we_o  out  1  register write enable
- regd_o  out  5  destination register
- res_o  out  32  writeback data
- op_o  out  5  opcode passthrough
- jump_o  out  32  jump offset passthrough
- misalign_o  out  1  misaligned-access flag (see Configuration)
- mem_req_o  out  1  byte request, held until ack
- mem_we_o  out  1  1 = write
- mem_addr_o  out  32  byte address
- mem_wdata_o  out  8  write byte
- mem_rdata_i  in  8  read byte, valid with ack
- mem_ack_i  in  1  transfer done

## Operation
- FSM: IDLE, XFER. A 2-bit byte counter `cnt` and the last index `last = (1<<sel[1:0]) - 1` are latched on accept.
- Accept: in IDLE with rdy && e_i. In XFER, e_i is ignored.
- Non-memory op:
  - Register the passthroughs and res_o = res_i.
  - e_o = 1.
  - we_o = (regd_i != 0) && op is not branch.
  - Stay in IDLE.
- Load/store accept:
  - Latch op, sel, regd, addr, data and jump.
  - Go to XFER with mem_req_o = 1, mem_addr_o = addr, mem_we_o = (op == store).
  - For stores, mem_wdata_o = data[7:0].
- XFER, on rdy && mem_ack_i:
  - Load: write mem_rdata_i into byte lane `cnt` of the assembly register.
  - If cnt == last: drop req, return to IDLE, pulse e_o.
  - Otherwise: cnt++, mem_addr_o++ (mod 2^32, so 0xFFFFFFFF wraps to 0), and mem_wdata_o = next data byte.
- Load result on completion:
  - sel 000: sign-extend bit 7.
  - sel 001: sign-extend bit 15.
  - sel 010: full word.
  - sel 100 and 101: zero-extend.
  - we_o = (regd != 0).
- Store completion: e_o = 1, we_o = 0, res_o = 0.
- Byte order: little-endian; byte 0 goes to the lowest address.
- rdy low: everything holds, including mem_req_o and the address; ack is not sampled.

## Timing
- Reset values:
  - All outputs 0 except jump_o = 32'h4.
  - FSM in IDLE, cnt = 0.
- Non-memory op: e_o is asserted the cycle after accept.
- Memory op of N bytes: req is asserted the cycle after accept. e_o is asserted the cycle after the Nth ack. Minimum latency is N+1 cycles.
- stall_o = (state == XFER), registered (Moore). It is high the cycle after accept through the cycle of the final ack.
- e_o, we_o and misalign_o are single-cycle pulses; they are 0 in every other cycle.
- Reset asserted mid-transfer:
  - Asynchronously drops mem_req_o and returns the FSM to IDLE.
  - The partial load is discarded; a partial store is not rolled back.
- An ack while req is low is ignored.

## Configuration
- MEM_STAGE_MISALIGN_TRAP_EN defined:
  - A misaligned access is an LH, LHU or SH with addr[0] set, or an LW or SW with addr[1:0] != 0.
  - Such an access issues no bus request and stays in IDLE.
  - Next cycle: e_o = 1, we_o = 0, misalign_o = 1.
- Undefined:
  - Misaligned accesses are performed byte-serially like any other access.
  - misalign_o is tied 0.

## Structure
- The shared package `cpu_pkg` holds:
  - OP_LOAD, OP_STORE, OP_BRANCH opcode constants.
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - The mem_stage state enum.
  - The JUMP_DEFAULT = 32'h4 constant.
- Sub-module `load_ext`: combinational; assembled word + sel → extended 32-bit result.

## Test plan
- Reset: rst_n low mid-run → all outputs 0, jump_o = 0x4, mem_req_o = 0, stall_o = 0.
- ALU op 01100, regd 5, res 0x1234 → next cycle e_o = 1, we_o = 1, res_o = 0x1234, no mem_req_o.
- LW at 0x100, acks on consecutive cycles returning 0x78, 0x56, 0x34, 0x12:
  - Addresses 0x100–0x103.
  - res_o = 0x12345678, e_o the cycle after the 4th ack.
  - stall_o high for 4 cycles.
- LB at 0x203 with rdata 0x80 → res_o = 0xFFFFFF80; LBU → 0x00000080. An LB to x0 → we_o = 0.
- SH at 0x10 with data 0xABCD:
  - Writes 0x10←0xCD, then 0x11←0xAB.
  - Completion: e_o = 1, we_o = 0.
  - Hold rdy low for 3 cycles mid-transfer with ack high → no progress, req and address stable.
- Macro defined: LW at 0x102 → no req, misalign_o = 1, we_o = 0. Macro undefined: a 4-byte transfer at 0x102–0x105.
